// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and defaults for the two-requester data_mem arbiter.
package data_mem_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/data_mem.sv
// Single-port word memory: registered read, write on writeEn, cleared by reset.
module data_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataInput,
  input  logic              writeEn,
  output logic [DATA_W-1:0] dataOutput
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_dout <= '0;
    end else begin
      if (writeEn) begin
        r_mem[address] <= dataInput;
      end
      r_dout <= r_mem[address];
    end
  end

  assign dataOutput = r_dout;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2
  import data_mem_ctrl_pkg::*;
(
  input  logic    i_valid0,
  input  logic    i_valid1,
  input  req_id_t i_last_grant,
  output logic    o_grant_valid,
  output req_id_t o_grant
);

  always_comb begin
    o_grant_valid = i_valid0 | i_valid1;
    o_grant       = REQ0;
    if (i_valid0 && i_valid1) begin
      o_grant = (i_last_grant == REQ0) ? REQ1 : REQ0;
    end else if (i_valid1) begin
      o_grant = REQ1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter giving two requesters single-word access to data_mem
// through a fixed IDLE -> ISSUE -> WAIT -> RESP sequence.
module data_mem_arbiter
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid0,
  input  logic              reqValid1,
  output logic              reqReady0,
  output logic              reqReady1,
  input  logic              reqWrite0,
  input  logic              reqWrite1,
  input  logic [ADDR_W-1:0] reqAddr0,
  input  logic [ADDR_W-1:0] reqAddr1,
  input  logic [DATA_W-1:0] reqWdata0,
  input  logic [DATA_W-1:0] reqWdata1,
  output logic              rspValid0,
  output logic              rspValid1,
  output logic [DATA_W-1:0] rspData0,
  output logic [DATA_W-1:0] rspData1,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memDataInput,
  output logic              memWriteEn,
  input  logic [DATA_W-1:0] memDataOutput,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next_state;
  req_id_t           r_last_grant;
  req_id_t           r_owner;
  req_id_t           w_grant;
  logic              w_grant_valid;
  logic              w_accept;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data0;
  logic [DATA_W-1:0] r_rsp_data1;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_arbiter2 u_arb (
    .i_valid0      (reqValid0),
    .i_valid1      (reqValid1),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign w_accept = (r_state == IDLE) && w_grant_valid;

  always_comb begin
    w_sel_write = reqWrite0;
    w_sel_addr  = reqAddr0;
    w_sel_wdata = reqWdata0;
    if (w_grant == REQ1) begin
      w_sel_write = reqWrite1;
      w_sel_addr  = reqAddr1;
      w_sel_wdata = reqWdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Ready is also gated by reset so it reads low while reset is held, not just after.
  always_comb begin
    reqReady0  = 1'b0;
    reqReady1  = 1'b0;
    rspValid0  = 1'b0;
    rspValid1  = 1'b0;
    memWriteEn = 1'b0;
    busy       = 1'b1;
    case (r_state)
      IDLE: begin
        busy      = 1'b0;
        reqReady0 = !reset && w_grant_valid && (w_grant == REQ0);
        reqReady1 = !reset && w_grant_valid && (w_grant == REQ1);
      end
      ISSUE:   memWriteEn = r_write;
      WAIT:    memWriteEn = 1'b0;
      RESP: begin
        rspValid0 = (r_owner == REQ0);
        rspValid1 = (r_owner == REQ1);
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= REQ1;
      r_owner      <= REQ0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_data0  <= '0;
      r_rsp_data1  <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_owner      <= w_grant;
        r_write      <= w_sel_write;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end
      if (r_state == WAIT) begin
        if (r_owner == REQ0) begin
          r_rsp_data0 <= r_write ? r_wdata : memDataOutput;
        end else begin
          r_rsp_data1 <= r_write ? r_wdata : memDataOutput;
        end
      end
    end
  end

  assign memAddress   = r_addr;
  assign memDataInput = r_wdata;
  assign rspData0     = r_rsp_data0;
  assign rspData1     = r_rsp_data1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter driving a data_mem instance.
module tb_data_mem_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reqValid0 = 1'b0, reqValid1 = 1'b0;
  logic          reqReady0, reqReady1;
  logic          reqWrite0 = 1'b0, reqWrite1 = 1'b0;
  logic [AW-1:0] reqAddr0 = '0, reqAddr1 = '0;
  logic [DW-1:0] reqWdata0 = '0, reqWdata1 = '0;
  logic          rspValid0, rspValid1;
  logic [DW-1:0] rspData0, rspData1;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memDataInput;
  logic          memWriteEn;
  logic [DW-1:0] memDataOutput;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int p0    = 0;
  int p1    = 0;
  int wide  = 0;
  int we_cnt = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .reqValid0     (reqValid0),
    .reqValid1     (reqValid1),
    .reqReady0     (reqReady0),
    .reqReady1     (reqReady1),
    .reqWrite0     (reqWrite0),
    .reqWrite1     (reqWrite1),
    .reqAddr0      (reqAddr0),
    .reqAddr1      (reqAddr1),
    .reqWdata0     (reqWdata0),
    .reqWdata1     (reqWdata1),
    .rspValid0     (rspValid0),
    .rspValid1     (rspValid1),
    .rspData0      (rspData0),
    .rspData1      (rspData1),
    .memAddress    (memAddress),
    .memDataInput  (memDataInput),
    .memWriteEn    (memWriteEn),
    .memDataOutput (memDataOutput),
    .busy          (busy)
  );

  data_mem #(.DATA_W(DW), .ADDR_W(AW)) u_mem (
    .clk        (clk),
    .reset      (reset),
    .address    (memAddress),
    .dataInput  (memDataInput),
    .writeEn    (memWriteEn),
    .dataOutput (memDataOutput)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rspValid0) p0++;
    if (rspValid1) p1++;
    if ((rspValid0 && prev0) || (rspValid1 && prev1)) wide++;
    if (memWriteEn) we_cnt++;
    prev0 = rspValid0;
    prev1 = rspValid1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic v, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      reqValid0 = v; reqWrite0 = wr; reqAddr0 = a; reqWdata0 = d;
    end else begin
      reqValid1 = v; reqWrite1 = wr; reqAddr1 = a; reqWdata1 = d;
    end
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? reqReady0 : reqReady1;
  endfunction

  // One full transaction from request to return to IDLE, checking every phase.
  task automatic run_txn(input string nm, input int id, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp, output int acc_cyc);
    int n = 0;
    set_req(id, 1'b1, wr, a, d);
    #1;
    while (!ready_of(id) && n < 16) begin
      tick();
      n++;
    end
    chk({nm, "_ready"}, ready_of(id), 1);
    chk({nm, "_ready_excl"}, reqReady0 & reqReady1, 0);
    tick();
    acc_cyc = cyc;
    set_req(id, 1'b0, 1'b0, '0, '0);
    chk({nm, "_issue_busy"}, busy, 1);
    chk({nm, "_issue_we"}, memWriteEn, wr);
    chk({nm, "_issue_addr"}, memAddress, a);
    chk({nm, "_issue_din"}, memDataInput, d);
    chk({nm, "_issue_rdy"}, reqReady0 | reqReady1, 0);
    tick();
    chk({nm, "_wait_we"}, memWriteEn, 0);
    chk({nm, "_wait_addr"}, memAddress, a);
    chk({nm, "_wait_din"}, memDataInput, d);
    chk({nm, "_wait_rdy"}, reqReady0 | reqReady1, 0);
    chk({nm, "_wait_rsp"}, rspValid0 | rspValid1, 0);
    tick();
    chk({nm, "_resp_valid"}, (id == 0) ? rspValid0 : rspValid1, 1);
    chk({nm, "_resp_other"}, (id == 0) ? rspValid1 : rspValid0, 0);
    chk({nm, "_resp_data"}, (id == 0) ? rspData0 : rspData1, exp);
    chk({nm, "_resp_we"}, memWriteEn, 0);
    chk({nm, "_resp_rdy"}, reqReady0 | reqReady1, 0);
    tick();
    chk({nm, "_idle_rsp"}, rspValid0 | rspValid1, 0);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_we"}, memWriteEn, 0);
    chk({nm, "_idle_addr_hold"}, memAddress, a);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int acc0, acc1, acc_tmp;
    int s0, s1, swe;

    // Reset state, with a request already pending.
    set_req(0, 1'b1, 1'b1, 8'h12, 8'h34);
    #3;
    chk("rst_ready0", reqReady0, 0);
    chk("rst_ready1", reqReady1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", memWriteEn, 0);
    chk("rst_addr", memAddress, 0);
    chk("rst_din", memDataInput, 0);
    chk("rst_rsp", {rspValid1, rspValid0}, 0);
    chk("rst_rdata", {rspData1, rspData0}, 0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    s0 = p0; s1 = p1;

    // Requester 0 write then read-back.
    run_txn("t1w", 0, 1'b1, 8'h3C, 8'hA5, 8'hA5, acc_tmp);
    run_txn("t1r", 0, 1'b0, 8'h3C, 8'h00, 8'hA5, acc_tmp);
    chk("t1_p0", p0 - s0, 2);
    chk("t1_p1", p1 - s1, 0);
    chk("t1_rd1", rspData1, 0);

    // Simultaneous requests right after reset: 0 wins, 1 follows 4 cycles later.
    pulse_reset();
    set_req(1, 1'b1, 1'b1, 8'h20, 8'h22);
    run_txn("t2a", 0, 1'b1, 8'h10, 8'h11, 8'h11, acc0);
    chk("t2_rd1_unchanged", rspData1, 0);
    run_txn("t2b", 1, 1'b1, 8'h20, 8'h22, 8'h22, acc1);
    chk("t2_spacing", acc1 - acc0, 4);
    run_txn("t2c", 0, 1'b0, 8'h10, 8'h00, 8'h11, acc_tmp);
    run_txn("t2d", 1, 1'b0, 8'h20, 8'h00, 8'h22, acc_tmp);

    // Both held valid: grants alternate starting with 0.
    s0 = p0; s1 = p1;
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_ready0", reqReady0, (k % 2) == 0);
      chk("t3_ready1", reqReady1, (k % 2) == 1);
      repeat (4) tick();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    chk("t3_p0", p0 - s0, 4);
    chk("t3_p1", p1 - s1, 4);
    chk("t3_rd0", rspData0, 8'h11);
    chk("t3_rd1", rspData1, 8'h22);

    // Read of the top address after memory reset.
    pulse_reset();
    swe = we_cnt;
    run_txn("t4", 1, 1'b0, 8'hFF, 8'h00, 8'h00, acc_tmp);
    chk("t4_no_we", we_cnt - swe, 0);

    // Reset landing during ISSUE of a write.
    set_req(0, 1'b1, 1'b1, 8'h40, 8'h77);
    #1;
    chk("t5_ready", reqReady0, 1);
    tick();
    chk("t5_issue_we", memWriteEn, 1);
    s0 = p0; s1 = p1;
    #1;
    reset = 1'b1;
    #1;
    chk("t5_we_low", memWriteEn, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready0", reqReady0, 0);
    chk("t5_rsp", {rspValid1, rspValid0}, 0);
    chk("t5_addr", memAddress, 0);
    chk("t5_din", memDataInput, 0);
    chk("t5_rdata", {rspData1, rspData0}, 0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t5_no_p0", p0 - s0, 0);
    chk("t5_no_p1", p1 - s1, 0);
    run_txn("t5r", 0, 1'b0, 8'h40, 8'h00, 8'h00, acc_tmp);

    chk("wide_pulses", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
